// File: rtl/demux_n_stream.sv
// demux_n_stream: routes one valid/ready stream to one of NUM_OUT channels, or to all of them on broadcast.
// Latency: 1 cycle from acceptance to out_valid; 1 beat/cycle per channel, drain and reload in the same cycle.
// Backpressure: in_ready = target slot free (all slots free for broadcast); illegal selects are always accepted and dropped.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       input handshake; in_data payload, in_sel target channel, in_bcast deliver to all
//   out_valid/out_ready     per-channel handshake, one bit per channel
//   out_data                channel k at [k*WIDTH +: WIDTH]; zero while the channel is idle
//   err_sel                 one-cycle pulse after a unicast beat with in_sel >= NUM_OUT is accepted
//   drop_cnt                (only with DEMUX_DROP_CNT_EN) saturating count of dropped illegal-select beats
//
// Build option: define DEMUX_DROP_CNT_EN to add the drop_cnt port and counter.
// Parameter rule: 2**SEL_W must be >= NUM_OUT, and NUM_OUT must be in 2..16.

module demux_n_stream #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic                       in_bcast,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [NUM_OUT*WIDTH-1:0]   out_data,
`ifdef DEMUX_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic                       err_sel
);

    localparam int SEL_SPAN = 2 ** SEL_W;

    // Per-channel one-entry slots
    logic [NUM_OUT-1:0] r_valid;
    logic [WIDTH-1:0]   r_data [NUM_OUT];
    logic               r_err_sel;

    logic [NUM_OUT-1:0]  w_free;
    logic [SEL_SPAN-1:0] w_free_pad;
    logic                w_sel_legal;
    logic                w_accept;
    logic                w_drop;
    logic [NUM_OUT-1:0]  w_load;

    // A slot can take a new beat when empty or when it drains this cycle.
    assign w_free = ~r_valid | out_ready;

    // Select codes past NUM_OUT index padding bits that read as free, so the
    // lookup stays in range; those beats are dropped regardless.
    always_comb begin
        w_free_pad              = '1;
        w_free_pad[NUM_OUT-1:0] = w_free;
    end

    assign w_sel_legal = (int'(in_sel) < NUM_OUT);

    always_comb begin
        if (in_bcast) begin
            in_ready = &w_free;            // all-or-nothing broadcast
        end else if (w_sel_legal) begin
            in_ready = w_free_pad[in_sel];
        end else begin
            in_ready = 1'b1;               // illegal select: swallow the beat
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_drop   = w_accept & ~in_bcast & ~w_sel_legal;

    // in_valid gates every load, so an unknown in_sel while idle loads nothing.
    always_comb begin
        w_load = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_load[k] = w_accept & (in_bcast | (w_sel_legal & (int'(in_sel) == k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_err_sel <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_err_sel <= w_drop;
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (r_valid[k] && out_ready[k]) begin
                    // Clear data on drain so idle channels present zero.
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign err_sel   = r_err_sel;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux_n_stream.sv
// tb_demux_n_stream: directed bench for demux_n_stream (4-channel instance plus 3-channel instance for illegal selects).
// Latency: inputs driven 1 ns after the rising edge, outputs compared 1 ns later.
// Backpressure: out_ready driven per scenario to stall individual channels.

module tb_demux_n_stream;

    logic        clk;
    logic        rst_n;

    // 4-channel instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [63:0] out_data;
    logic        err_sel;

    // 3-channel instance
    logic        d3_in_valid;
    logic        d3_in_ready;
    logic [15:0] d3_in_data;
    logic [1:0]  d3_in_sel;
    logic        d3_in_bcast;
    logic [2:0]  d3_out_valid;
    logic [2:0]  d3_out_ready;
    logic [47:0] d3_out_data;
    logic        d3_err_sel;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]  drop_cnt4;
    logic [7:0]  d3_drop_cnt;
`endif

    int total;
    int bad;

    demux_n_stream #(.WIDTH(16), .NUM_OUT(4), .SEL_W(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt  (drop_cnt4),
`endif
        .err_sel   (err_sel)
    );

    demux_n_stream #(.WIDTH(16), .NUM_OUT(3), .SEL_W(2)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .in_data   (d3_in_data),
        .in_sel    (d3_in_sel),
        .in_bcast  (d3_in_bcast),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .out_data  (d3_out_data),
`ifdef DEMUX_DROP_CNT_EN
        .drop_cnt  (d3_drop_cnt),
`endif
        .err_sel   (d3_err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_sel       = '0;
        in_bcast     = 1'b0;
        out_ready    = 4'b1111;
        d3_in_valid  = 1'b0;
        d3_in_data   = '0;
        d3_in_sel    = '0;
        d3_in_bcast  = 1'b0;
        d3_out_ready = 3'b111;

        // ---- reset state
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err_sel", err_sel, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_d3_out_valid", d3_out_valid, 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // ---- single unicast beat to channel 2
        cyc();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 16'hA5A5; out_ready = 4'b1111;
        #1;
        chk("uni_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("uni_out_valid", out_valid, 4'b0100);
        chk("uni_out_data", out_data, 64'h0000_A5A5_0000_0000);
        cyc();
        #1;
        chk("uni_drained_valid", out_valid, 0);
        chk("uni_drained_data", out_data, 0);

        // ---- stall on channel 1
        cyc();
        in_valid = 1'b1; in_sel = 2'd1; in_data = 16'h0011; out_ready = 4'b1101;
        #1;
        chk("stall_first_rdy", in_ready, 1);
        cyc();
        in_data = 16'h0022;
        #1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 4'b0010);
        chk("stall_data_a", out_data, 64'h0000_0000_0011_0000);
        cyc();
        #1;
        chk("stall_hold_rdy", in_ready, 0);
        chk("stall_data_b", out_data, 64'h0000_0000_0011_0000);
        cyc();
        out_ready = 4'b1111;
        #1;
        chk("stall_release_rdy", in_ready, 1);
        chk("stall_data_c", out_data, 64'h0000_0000_0011_0000);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("stall_second_valid", out_valid, 4'b0010);
        chk("stall_second_data", out_data, 64'h0000_0000_0022_0000);
        cyc();
        #1;
        chk("stall_empty", out_valid, 0);

        // ---- broadcast, then broadcast blocked by stalled channel 3
        cyc();
        in_valid = 1'b1; in_bcast = 1'b1; in_sel = 2'd0; in_data = 16'h1234; out_ready = 4'b1111;
        #1;
        chk("bc_in_ready", in_ready, 1);
        cyc();
        in_data = 16'h5678; out_ready = 4'b0111;
        #1;
        chk("bc_out_valid", out_valid, 4'b1111);
        chk("bc_out_data", out_data, 64'h1234_1234_1234_1234);
        chk("bc_blocked_rdy", in_ready, 0);
        cyc();
        in_valid = 1'b0; in_bcast = 1'b0;
        #1;
        chk("bc_blocked_valid", out_valid, 4'b1000);
        chk("bc_blocked_data", out_data, 64'h1234_0000_0000_0000);
        out_ready = 4'b1111;
        cyc();
        #1;
        chk("bc_empty", out_valid, 0);

        // ---- 8 back-to-back beats to channel 0
        for (int i = 0; i < 8; i++) begin
            cyc();
            in_valid = 1'b1; in_sel = 2'd0; in_data = 16'(i); out_ready = 4'b1111;
            #1;
            chk("b2b_in_ready", in_ready, 1);
            if (i > 0) begin
                chk("b2b_valid", out_valid, 4'b0001);
                chk("b2b_data", out_data, 64'(i - 1));
            end
        end
        cyc();
        in_valid = 1'b0;
        #1;
        chk("b2b_last_valid", out_valid, 4'b0001);
        chk("b2b_last_data", out_data, 64'd7);
        cyc();
        #1;
        chk("b2b_empty", out_valid, 0);

        // ---- illegal select on the 3-channel instance
        cyc();
        d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_bcast = 1'b0; d3_in_data = 16'hDEAD;
        #1;
        chk("ill_in_ready", d3_in_ready, 1);
        chk("ill_err_before", d3_err_sel, 0);
        cyc();
        d3_in_valid = 1'b0;
        #1;
        chk("ill_err_pulse", d3_err_sel, 1);
        chk("ill_no_valid", d3_out_valid, 0);
        chk("ill_no_data", d3_out_data, 0);
`ifdef DEMUX_DROP_CNT_EN
        chk("ill_drop_cnt_1", d3_drop_cnt, 1);
`endif
        cyc();
        #1;
        chk("ill_err_cleared", d3_err_sel, 0);

        // broadcast ignores an out-of-range select
        d3_in_valid = 1'b1; d3_in_bcast = 1'b1; d3_in_sel = 2'd3; d3_in_data = 16'hBEEF;
        #1;
        chk("ill_bc_rdy", d3_in_ready, 1);
        cyc();
        d3_in_valid = 1'b0; d3_in_bcast = 1'b0;
        #1;
        chk("ill_bc_err", d3_err_sel, 0);
        chk("ill_bc_valid", d3_out_valid, 3'b111);
        chk("ill_bc_data", d3_out_data, 48'hBEEF_BEEF_BEEF);

        // legal top channel on the 3-channel instance
        cyc();
        d3_in_valid = 1'b1; d3_in_sel = 2'd2; d3_in_data = 16'h0C0C;
        cyc();
        d3_in_valid = 1'b0;
        #1;
        chk("d3_top_err", d3_err_sel, 0);
        chk("d3_top_valid", d3_out_valid, 3'b100);
        chk("d3_top_data", d3_out_data, 48'h0C0C_0000_0000);

`ifdef DEMUX_DROP_CNT_EN
        // 300 more illegal beats saturate the counter
        cyc();
        d3_in_valid = 1'b1; d3_in_sel = 2'd3;
        for (int i = 0; i < 300; i++) begin
            cyc();
        end
        d3_in_valid = 1'b0;
        #1;
        chk("drop_cnt_sat", d3_drop_cnt, 255);
        cyc();
`endif

        // ---- asynchronous reset with all slots full and err_sel high
        cyc();
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'hCAFE; out_ready = 4'b0000;
        d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_bcast = 1'b0;
        cyc();
        in_valid = 1'b0; in_bcast = 1'b0; d3_in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", out_valid, 4'b1111);
        chk("pre_rst_data", out_data, 64'hCAFE_CAFE_CAFE_CAFE);
        chk("pre_rst_d3_err", d3_err_sel, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_err", err_sel, 0);
        chk("arst_d3_err", d3_err_sel, 0);
        chk("arst_d3_valid", d3_out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
`ifdef DEMUX_DROP_CNT_EN
        chk("arst_drop_cnt", d3_drop_cnt, 0);
`endif
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
